connect4_win_checker: RTL and testbench

- Reads the 6x7 board produced by the column-drop grid logic and decides whether the player who just moved has four in a row, or whether the board is a draw.
- Takes a snapshot of the board on a start pulse, then scans one anchor cell per cycle.
- Reports win, draw, and the winning line's anchor cell and direction to the game-control FSM and display.

---
 rtl/connect4_win_checker_if.sv | 28 ++
 rtl/connect4_win_checker.sv | 211 +++++++++++++++++++++
 tb/tb_connect4_win_checker.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/connect4_win_checker_if.sv
// connect4_win_checker_if: request/result bundle between the game-control
// FSM (master) and the win checker (slave). The board is a packed grid
// indexed [row][col], each cell 2 bits: 00 empty, 01 P1, 10 P2.
interface connect4_win_checker_if #(
  parameter int ROWS = 6,
  parameter int COLS = 7
);
  logic                                start;
  logic [1:0]                          check_player;
  logic [0:ROWS-1][0:COLS-1][1:0]      grid_in;
  logic                                busy;
  logic                                done;
  logic                                win;
  logic                                draw;
  logic [2:0]                          win_row;
  logic [2:0]                          win_col;
  logic [1:0]                          win_dir;

  modport master (
    output start, check_player, grid_in,
    input  busy, done, win, draw, win_row, win_col, win_dir
  );

  modport slave (
    input  start, check_player, grid_in,
    output busy, done, win, draw, win_row, win_col, win_dir
  );
endinterface

// File: rtl/connect4_win_checker.sv
// connect4_win_checker: snapshots the board on start, then scans one anchor
// cell per cycle in row-major order looking for four in a row for the
// snapshot player (directions H, V, DR, DL in priority order). The first
// match is latched; draw is reported when the top row is full with no win.
// Optional build macro WIN_EARLY_EXIT_EN: leave SCAN right after the first
// matching anchor instead of always scanning every anchor.
module connect4_win_checker #(
  parameter int ROWS = 6,
  parameter int COLS = 7
) (
  input logic                    clk,
  input logic                    rst_n,
  connect4_win_checker_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef logic [0:ROWS-1][0:COLS-1][1:0] grid_t;

  localparam logic [2:0] LAST_ROW = 3'(ROWS - 1);
  localparam logic [2:0] LAST_COL = 3'(COLS - 1);

  localparam logic [1:0] DIR_H  = 2'b00;
  localparam logic [1:0] DIR_V  = 2'b01;
  localparam logic [1:0] DIR_DR = 2'b10;
  localparam logic [1:0] DIR_DL = 2'b11;

  state_t     state_q,   state_d;
  grid_t      snap_q,    snap_d;
  logic [1:0] player_q,  player_d;
  logic [2:0] row_q,     row_d;
  logic [2:0] col_q,     col_d;
  logic       win_q,     win_d;
  logic       draw_q,    draw_d;
  logic [2:0] win_row_q, win_row_d;
  logic [2:0] win_col_q, win_col_d;
  logic [1:0] win_dir_q, win_dir_d;

  logic       player_valid;
  logic [3:0] dir_hit;
  logic       anchor_hit;
  logic [1:0] hit_dir;
  logic       last_anchor;
  logic       top_full;
  logic       go_done;

  // True when the four cells starting at (r,c) stepping (dr,dc) are all on
  // the board and all hold player p.
  function automatic logic line_match(input grid_t      g,
                                      input logic [1:0] p,
                                      input logic [2:0] r,
                                      input logic [2:0] c,
                                      input int         dr,
                                      input int         dc);
    int rr;
    int cc;
    line_match = 1'b1;
    for (int s = 0; s < 4; s++) begin
      rr = int'(r) + s * dr;
      cc = int'(c) + s * dc;
      if (rr < 0 || rr >= ROWS || cc < 0 || cc >= COLS) begin
        line_match = 1'b0;
      end else if (g[rr[2:0]][cc[2:0]] != p) begin
        line_match = 1'b0;
      end
    end
  endfunction

  // Only P1/P2 can ever own a line; 00 and 11 never match.
  assign player_valid = (player_q == 2'b01) || (player_q == 2'b10);

  assign dir_hit[0] = player_valid && line_match(snap_q, player_q, row_q, col_q, 0,  1);
  assign dir_hit[1] = player_valid && line_match(snap_q, player_q, row_q, col_q, 1,  0);
  assign dir_hit[2] = player_valid && line_match(snap_q, player_q, row_q, col_q, 1,  1);
  assign dir_hit[3] = player_valid && line_match(snap_q, player_q, row_q, col_q, 1, -1);

  assign anchor_hit  = |dir_hit;
  assign last_anchor = (row_q == LAST_ROW) && (col_q == LAST_COL);

  // Priority encode the matching direction: H beats V beats DR beats DL.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    hit_dir = DIR_H;
    if (dir_hit[0])      hit_dir = DIR_H;
    else if (dir_hit[1]) hit_dir = DIR_V;
    else if (dir_hit[2]) hit_dir = DIR_DR;
    else if (dir_hit[3]) hit_dir = DIR_DL;
  end

  // Board is full exactly when every top-row cell is occupied.
  always_comb begin
    top_full = 1'b1;
    for (int c = 0; c < COLS; c++) begin
      if (snap_q[0][c] == 2'b00) top_full = 1'b0;
    end
  end

  // Next-state logic: accept in IDLE, walk anchors in SCAN, pulse in DONE.
  always_comb begin
    state_d   = state_q;
    snap_d    = snap_q;
    player_d  = player_q;
    row_d     = row_q;
    col_d     = col_q;
    win_d     = win_q;
    draw_d    = draw_q;
    win_row_d = win_row_q;
    win_col_d = win_col_q;
    win_dir_d = win_dir_q;
    go_done   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          snap_d    = bus.grid_in;
          player_d  = bus.check_player;
          row_d     = 3'd0;
          col_d     = 3'd0;
          win_d     = 1'b0;
          draw_d    = 1'b0;
          win_row_d = 3'd0;
          win_col_d = 3'd0;
          win_dir_d = 2'b00;
          state_d   = S_SCAN;
        end
      end

      S_SCAN: begin
        // Only the first matching anchor is recorded.
        if (anchor_hit && !win_q) begin
          win_d     = 1'b1;
          win_row_d = row_q;
          win_col_d = col_q;
          win_dir_d = hit_dir;
        end

        if (col_q == LAST_COL) begin
          col_d = 3'd0;
          row_d = row_q + 3'd1;
        end else begin
          col_d = col_q + 3'd1;
        end

        go_done = last_anchor;
`ifdef WIN_EARLY_EXIT_EN
        if (anchor_hit) go_done = 1'b1;
`endif

        // Draw is settled on the way into DONE so it is valid with done.
        if (go_done) begin
          draw_d  = top_full && !win_d;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, snapshot and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the snapshot is ordinary flops (not a RAM), so it is reset
      // along with the results; a board left over from an aborted check
      // must not be observable after reset.
      state_q   <= S_IDLE;
      snap_q    <= '0;
      player_q  <= 2'b00;
      row_q     <= 3'd0;
      col_q     <= 3'd0;
      win_q     <= 1'b0;
      draw_q    <= 1'b0;
      win_row_q <= 3'd0;
      win_col_q <= 3'd0;
      win_dir_q <= 2'b00;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      state_q   <= state_d;
      snap_q    <= snap_d;
      player_q  <= player_d;
      row_q     <= row_d;
      col_q     <= col_d;
      win_q     <= win_d;
      draw_q    <= draw_d;
      win_row_q <= win_row_d;
      win_col_q <= win_col_d;
      win_dir_q <= win_dir_d;
    end
  end

  assign bus.busy    = (state_q != S_IDLE);
  assign bus.done    = (state_q == S_DONE);
  assign bus.win     = win_q;
  assign bus.draw    = draw_q;
  assign bus.win_row = win_row_q;
  assign bus.win_col = win_col_q;
  assign bus.win_dir = win_dir_q;

endmodule

// File: tb/tb_connect4_win_checker.sv
// tb_connect4_win_checker: directed and random boards against a reference
// model that searches the board for the first four-in-a-row in row-major
// anchor order with H, V, DR, DL priority.
module tb_connect4_win_checker;

  localparam int ROWS = 6;
  localparam int COLS = 7;
  localparam int MAXN = 100;

  logic clk;
  logic rst_n;

  int n_checks = 0;
  int n_err    = 0;

  logic [1:0] board [ROWS][COLS];

  connect4_win_checker_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

  connect4_win_checker #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_board();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        board[r][c] = 2'b00;
  endtask

  task automatic load_grid();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        bus.grid_in[r][c] = board[r][c];
  endtask

  // Reference: first anchor (row-major) with a full line for p, first
  // direction in H, V, DR, DL order; draw when top row full and no win.
  task automatic model(input logic [1:0] p, output bit w, output bit d,
                       output int wr, output int wc, output int wd, output int k);
    int dr [4];
    int dc [4];
    int rr, cc, cnt;
    bit full;
    dr = '{0, 1, 1, 1};
    dc = '{1, 0, 1, -1};
    w = 0; wr = 0; wc = 0; wd = 0; k = ROWS * COLS;
    if (p == 2'b01 || p == 2'b10) begin
      for (int a = 0; a < ROWS * COLS && !w; a++) begin
        for (int dir = 0; dir < 4 && !w; dir++) begin
          cnt = 0;
          for (int s = 0; s < 4; s++) begin
            rr = a / COLS + s * dr[dir];
            cc = a % COLS + s * dc[dir];
            if (rr >= 0 && rr < ROWS && cc >= 0 && cc < COLS && board[rr][cc] == p) cnt++;
          end
          if (cnt == 4) begin
            w = 1; wr = a / COLS; wc = a % COLS; wd = dir; k = a;
          end
        end
      end
    end
    full = 1;
    for (int c = 0; c < COLS; c++) if (board[0][c] == 2'b00) full = 0;
    d = full && !w;
  endtask

  // Issue one check starting now (we are #1 after an edge, DUT in IDLE) and
  // follow it through done. mode 1 adds the snapshot-isolation disturbances.
  task automatic run_check(input string name, input logic [1:0] p, input int mode);
    bit ew, ed;
    int er, ec, edir, ek, exp_n;
    int n, first_n, dones;
    bit found;
    model(p, ew, ed, er, ec, edir, ek);
`ifdef WIN_EARLY_EXIT_EN
    exp_n = ew ? ek + 2 : ROWS * COLS + 1;
`else
    exp_n = ROWS * COLS + 1;
`endif
    load_grid();
    bus.check_player = p;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check({name, ".busy_t1"}, bus.busy, 1);
    check({name, ".win_cleared"}, bus.win, 0);
    found = 0; first_n = 0; dones = 0; n = 1;
    while (n <= MAXN) begin
      if (mode == 1 && n == 3) begin
        clear_board();
        for (int c = 0; c < 4; c++) board[5][c] = 2'b01;
        load_grid();
      end
      if (mode == 1 && n == 5) bus.start = 1'b1;
      if (mode == 1 && n == 6) bus.start = 1'b0;
      if (bus.done) begin
        dones++;
        if (!found) begin
          found = 1;
          first_n = n;
          check({name, ".latency"}, first_n, exp_n);
          check({name, ".win"},     bus.win, ew);
          check({name, ".draw"},    bus.draw, ed);
          check({name, ".win_row"}, bus.win_row, er);
          check({name, ".win_col"}, bus.win_col, ec);
          check({name, ".win_dir"}, bus.win_dir, edir);
        end
      end
      if (found && n == first_n + 1) begin
        check({name, ".done_once"}, bus.done, 0);
        check({name, ".busy_fall"}, bus.busy, 0);
        check({name, ".win_hold"},  bus.win, ew);
        break;
      end
      @(posedge clk); #1;
      n++;
    end
    bus.start = 1'b0;
    check({name, ".done_seen"}, found, 1);
    check({name, ".done_count"}, dones, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.check_player = 2'b00;
    bus.grid_in = '0;
    clear_board();

    // Reset state.
    #3;
    check("rst.busy",    bus.busy, 0);
    check("rst.done",    bus.done, 0);
    check("rst.win",     bus.win, 0);
    check("rst.draw",    bus.draw, 0);
    check("rst.win_row", bus.win_row, 0);
    check("rst.win_col", bus.win_col, 0);
    check("rst.win_dir", bus.win_dir, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Horizontal win on the bottom row.
    clear_board();
    for (int c = 0; c < 4; c++) board[5][c] = 2'b01;
    run_check("horiz", 2'b01, 0);

    // Vertical P2 win, then the same board for the wrong player.
    clear_board();
    for (int r = 2; r < 6; r++) board[r][6] = 2'b10;
    run_check("vert_p2", 2'b10, 0);
    run_check("vert_p1", 2'b01, 0);

    // Down-left diagonal.
    clear_board();
    board[2][3] = 2'b01; board[3][2] = 2'b01; board[4][1] = 2'b01; board[5][0] = 2'b01;
    run_check("diag_dl", 2'b01, 0);

    // Anchor (0,0) matches both H and V: H wins on priority.
    clear_board();
    for (int i = 0; i < 4; i++) begin
      board[0][i] = 2'b01;
      board[i][0] = 2'b01;
    end
    run_check("prio_hv", 2'b01, 0);

    // Full board with no line for either player: draw.
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        board[r][c] = ((((c + 2 * r) / 2) % 2) == 0) ? 2'b01 : 2'b10;
    run_check("draw_p1", 2'b01, 0);
    run_check("draw_p2", 2'b10, 0);

    // Invalid player codes never win.
    clear_board();
    for (int c = 0; c < 4; c++) board[1][c] = 2'b11;
    run_check("player11", 2'b11, 0);

    // Snapshot isolation: empty board, grid change at T+3, extra start at T+5.
    clear_board();
    run_check("isolate", 2'b01, 1);
    @(posedge clk); #1;

    // Reset mid-scan at T+10.
    clear_board();
    for (int c = 0; c < 4; c++) board[0][c] = 2'b01;
    load_grid();
    bus.check_player = 2'b01;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("midrst.win_before", bus.win, 1);
    rst_n = 1'b0;
    #1;
    check("midrst.busy",    bus.busy, 0);
    check("midrst.done",    bus.done, 0);
    check("midrst.win",     bus.win, 0);
    check("midrst.draw",    bus.draw, 0);
    check("midrst.win_row", bus.win_row, 0);
    check("midrst.win_col", bus.win_col, 0);
    check("midrst.win_dir", bus.win_dir, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("midrst.no_done", bus.done, 0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    clear_board();
    for (int r = 1; r < 5; r++) board[r][r + 1] = 2'b10;
    run_check("after_rst", 2'b10, 0);

    // Random boards, issued back to back.
    for (int t = 0; t < 24; t++) begin
      bit full_mode;
      logic [1:0] p;
      full_mode = ($urandom_range(0, 3) == 0);
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          board[r][c] = full_mode ? 2'($urandom_range(1, 2)) : 2'($urandom_range(0, 2));
      if ($urandom_range(0, 9) < 8) p = 2'($urandom_range(1, 2));
      else p = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
      run_check($sformatf("rand%0d", t), p, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
